// File: rtl/lm_ctrl_pkg.sv
// Shared LEGv8 control definitions: FSM state codes, instruction classes and
// opcode match constants (value/mask pairs), also used by the single-cycle decoder.
package lm_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_S  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_LD, CLS_ST, CLS_CBZ, CLS_CBNZ, CLS_B, CLS_IMM, CLS_ILL
  } iclass_t;

  localparam int WAIT_W = 8;

  // Values are pre-masked so a match is simply (op & mask) == val.
  localparam logic [10:0] OP_R_VAL    = 11'b10001010000;
  localparam logic [10:0] OP_R_MASK   = 11'b10011110111;
  localparam logic [10:0] OP_LDUR     = 11'b11111000010;
  localparam logic [10:0] OP_STUR     = 11'b11111000000;
  localparam logic [10:0] OP_CBZ_VAL  = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ_VAL = 11'b10110101000;
  localparam logic [10:0] OP_CB_MASK  = 11'b11111111000;
  localparam logic [10:0] OP_B_VAL    = 11'b00010100000;
  localparam logic [10:0] OP_B_MASK   = 11'b11111100000;
  localparam logic [10:0] OP_ADDI_VAL = 11'b10010001000;
  localparam logic [10:0] OP_SUBI_VAL = 11'b11010001000;
  localparam logic [10:0] OP_IMM_MASK = 11'b11111111110;

  function automatic logic op_match(logic [10:0] op, logic [10:0] val, logic [10:0] mask);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/lm_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: opcode, flags, handshakes and control lines.
interface lm_multicycle_ctrl_if #(
  parameter int OPCODE_W = 11,
  parameter int CNT_W    = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                instr_ready;
  logic                mem_ready;
  logic                instr_req, IRWrite, PCWrite, PCSrc;
  logic                Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic                Branch, ALUOp1, ALUOp0, Uncond;
  logic                illegal, timeout;
  logic [CNT_W-1:0]    retired;
  logic [2:0]          state;

  modport master (
    input  opcode, zero, instr_ready, mem_ready,
    output instr_req, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg,
           RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0, Uncond,
           illegal, timeout, retired, state
  );

  modport slave (
    output opcode, zero, instr_ready, mem_ready,
    input  instr_req, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg,
           RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0, Uncond,
           illegal, timeout, retired, state
  );
endinterface

// File: rtl/lm_opcode_classify.sv
// Combinational opcode -> instruction class; ADDI/SUBI fold into CLS_IMM with imm_sub.
module lm_opcode_classify
  import lm_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int EN_IMM   = 1
) (
  input  logic [OPCODE_W-1:0] opcode,
  output iclass_t             cls,
  output logic                imm_sub
);

  always_comb begin
    cls     = CLS_ILL;
    imm_sub = 1'b0;
    if (op_match(opcode, OP_R_VAL, OP_R_MASK))                      cls = CLS_R;
    else if (op_match(opcode, OP_LDUR, 11'h7ff))                    cls = CLS_LD;
    else if (op_match(opcode, OP_STUR, 11'h7ff))                    cls = CLS_ST;
    else if (op_match(opcode, OP_CBZ_VAL, OP_CB_MASK))              cls = CLS_CBZ;
    else if (op_match(opcode, OP_CBNZ_VAL, OP_CB_MASK))             cls = CLS_CBNZ;
    else if (op_match(opcode, OP_B_VAL, OP_B_MASK))                 cls = CLS_B;
    else if ((EN_IMM != 0) && op_match(opcode, OP_ADDI_VAL, OP_IMM_MASK)) cls = CLS_IMM;
    else if ((EN_IMM != 0) && op_match(opcode, OP_SUBI_VAL, OP_IMM_MASK)) begin
      cls     = CLS_IMM;
      imm_sub = 1'b1;
    end
  end

endmodule

// File: rtl/lm_multicycle_ctrl.sv
// Multi-cycle LEGv8 control unit: fetch/decode/exec/mem/wb sequencing with
// memory-ready timeout, illegal-opcode trap and retired-instruction counter.
//
// state  | meaning
// RST_S  | reset, leaves on first edge after rst drops
// FETCH  | instr_req high, waits instr_ready (loads IR, PC+4)
// DECODE | classify opcode, latch class
// EXEC   | ALU controls; branches resolve and retire here
// MEM    | data access, waits mem_ready
// WB     | register write-back, retires
// TRAP   | illegal opcode or timeout, held until rst
module lm_multicycle_ctrl
  import lm_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 32,
  parameter int EN_IMM   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  lm_multicycle_ctrl_if.master  bus
);

  state_t              state_q, state_d;
  iclass_t             cls_d, cls_q;
  logic                sub_d, sub_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [CNT_W-1:0]    retired_q;
  logic                illegal_q, timeout_q;
  logic                retire, set_ill, set_tmo, wait_last, taken;

  lm_opcode_classify #(.OPCODE_W(OPCODE_W), .EN_IMM(EN_IMM)) u_classify (
    .opcode  (bus.opcode),
    .cls     (cls_d),
    .imm_sub (sub_d)
  );

  assign wait_last = (wait_q == WAIT_W'(TIMEOUT - 1));
  assign taken     = bus.zero ^ (cls_q == CLS_CBNZ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RST_S;
      cls_q     <= CLS_ILL;
      sub_q     <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        cls_q <= cls_d;
        sub_q <= sub_d;
      end
      // Staying in FETCH/MEM can only mean the ready has not arrived yet.
      if (state_d != state_q)                      wait_q <= '0;
      else if (state_q == FETCH || state_q == MEM) wait_q <= wait_q + WAIT_W'(1);
      if (retire)  retired_q <= retired_q + CNT_W'(1);
      if (set_ill) illegal_q <= 1'b1;
      if (set_tmo) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    set_ill      = 1'b0;
    set_tmo      = 1'b0;
    bus.instr_req = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSrc    = 1'b0;
    bus.Reg2Loc  = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Branch   = 1'b0;
    bus.ALUOp1   = 1'b0;
    bus.ALUOp0   = 1'b0;
    bus.Uncond   = 1'b0;
    case (state_q)
      RST_S: state_d = FETCH;
      FETCH: begin
        bus.instr_req = 1'b1;
        if (bus.instr_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          state_d     = DECODE;
        end else if (wait_last) begin
          state_d = TRAP;
          set_tmo = 1'b1;
        end
      end
      DECODE: begin
        if (cls_d == CLS_ILL) begin
          state_d = TRAP;
          set_ill = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = WB;
        case (cls_q)
          CLS_R:  {bus.ALUOp1, bus.ALUOp0} = 2'b10;
          CLS_LD: begin bus.ALUSrc = 1'b1; state_d = MEM; end
          CLS_ST: begin bus.ALUSrc = 1'b1; bus.Reg2Loc = 1'b1; state_d = MEM; end
          CLS_IMM: begin
            bus.ALUSrc = 1'b1;
            {bus.ALUOp1, bus.ALUOp0} = sub_q ? 2'b10 : 2'b00;
          end
          CLS_CBZ, CLS_CBNZ: begin
            {bus.ALUOp1, bus.ALUOp0} = 2'b01;
            bus.Reg2Loc = 1'b1;
            bus.Branch  = 1'b1;
            bus.PCWrite = taken;
            bus.PCSrc   = taken;
            state_d     = FETCH;
            retire      = 1'b1;
          end
          CLS_B: begin
            {bus.ALUOp1, bus.ALUOp0} = 2'b01;
            bus.Uncond  = 1'b1;
            bus.PCWrite = 1'b1;
            bus.PCSrc   = 1'b1;
            state_d     = FETCH;
            retire      = 1'b1;
          end
          default: state_d = TRAP;
        endcase
      end
      MEM: begin
        bus.ALUSrc   = 1'b1;
        bus.MemRead  = (cls_q == CLS_LD);
        bus.MemWrite = (cls_q == CLS_ST);
        if (bus.mem_ready) begin
          if (cls_q == CLS_LD) begin
            state_d = WB;
          end else begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        end else if (wait_last) begin
          state_d = TRAP;
          set_tmo = 1'b1;
        end
      end
      WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = (cls_q == CLS_LD);
        state_d      = FETCH;
        retire       = 1'b1;
      end
      TRAP:    state_d = TRAP;
      default: state_d = RST_S;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.retired = retired_q;
  assign bus.illegal = illegal_q;
  assign bus.timeout = timeout_q;

endmodule
